// File: rtl/le_cmp_scheduler.sv
// Round-robin scheduler that shares one pipelined FP less-or-equal comparator between NREQ
// requesters, tagging each issue and buffering tagged results in a credit-guarded FIFO.
module le_cmp_scheduler #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned CMP_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 5,
    localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_a,
    input  logic [NREQ*(WIDTH+1)-1:0]   req_b,
    output logic [WIDTH:0]              cmp_a,
    output logic [WIDTH:0]              cmp_b,
    input  logic                        cmp_le,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic                        rsp_le,
    output logic                        busy
);

    localparam int unsigned OPW  = WIDTH + 1;
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [OPW-1:0]  cmp_a_q, cmp_a_d;
    logic [OPW-1:0]  cmp_b_q, cmp_b_d;
    logic [CMP_LAT-1:0] vpipe_q, vpipe_d;
    logic [IDW-1:0]  tpipe_q [CMP_LAT];
    logic [IDW-1:0]  tpipe_d [CMP_LAT];

    logic [PTRW-1:0] wr_q, wr_d;
    logic [PTRW-1:0] rd_q, rd_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic [IDW-1:0]  mem_id [FIFO_DEPTH];
    logic            mem_le [FIFO_DEPTH];

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  scan_idx;
    logic            found;
    logic            credit_ok;
    logic            accept;
    logic            push;
    logic            pop;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // Rotating priority search starting at ptr_q.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[scan_idx]) begin
                found           = 1'b1;
                grant[scan_idx] = 1'b1;
                gnt_idx         = scan_idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*OPW +: OPW];
                sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    // Grant is withheld while in reset so nothing appears accepted.
    assign credit_ok = rst && (cnt_q < CNTW'(FIFO_DEPTH));
    assign req_ready = credit_ok ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign push      = vpipe_q[CMP_LAT-1];
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        ptr_d   = ptr_q;
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        if (accept) begin
            ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            cmp_a_d = sel_a;
            cmp_b_d = sel_b;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        vpipe_d[0] = accept;
        tpipe_d[0] = gnt_idx;
        for (int i = 1; i < CMP_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            tpipe_d[i] = tpipe_q[i-1];
        end
    end

    always_comb begin
        wr_d   = push ? ptr_inc(wr_q) : wr_q;
        rd_d   = pop ? ptr_inc(rd_q) : rd_q;
        fcnt_d = fcnt_q;
        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CNTW'(1);
            2'b01:   fcnt_d = fcnt_q - CNTW'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            vpipe_q <= '0;
            for (int i = 0; i < CMP_LAT; i++) begin
                tpipe_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            vpipe_q <= vpipe_d;
            for (int i = 0; i < CMP_LAT; i++) begin
                tpipe_q[i] <= tpipe_d[i];
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Storage needs no reset: the occupancy count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_q] <= tpipe_q[CMP_LAT-1];
            mem_le[wr_q] <= cmp_le;
        end
    end

    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign rsp_valid = (fcnt_q != '0);
    assign rsp_id    = rsp_valid ? mem_id[rd_q] : '0;
    assign rsp_le    = rsp_valid ? mem_le[rd_q] : 1'b0;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_le_cmp_scheduler.sv
// Scoreboard bench for le_cmp_scheduler with a behavioural 3-edge FP compare model.
module tb_le_cmp_scheduler;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned OPW   = WIDTH + 1;

    localparam logic [32:0] ONE  = 33'h09FF80000;
    localparam logic [32:0] TWO  = 33'h0A0000000;
    localparam logic [32:0] NEG2 = 33'h0E0000000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OPW-1:0]    req_a;
    logic [NREQ*OPW-1:0]    req_b;
    logic [WIDTH:0]         cmp_a;
    logic [WIDTH:0]         cmp_b;
    logic                   cmp_le;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic                   rsp_le;
    logic                   busy;

    always #5 clk = ~clk;

    le_cmp_scheduler #(
        .WIDTH(WIDTH), .NREQ(NREQ), .CMP_LAT(3), .FIFO_DEPTH(5)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_le(cmp_le),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_le(rsp_le), .busy(busy)
    );

    // Comparator model: two registers after cmp_a/cmp_b, holds on non-normal inputs.
    function automatic logic fp_le(input logic [32:0] a, input logic [32:0] b);
        if (a[30] != b[30]) return a[30];
        if (!a[30]) return a[29:0] <= b[29:0];
        return a[29:0] >= b[29:0];
    endfunction

    logic le_s1 = 1'b0;
    logic le_s2 = 1'b0;
    always @(posedge clk) begin
        if (cmp_a[32:31] == 2'b01 && cmp_b[32:31] == 2'b01) le_s1 <= fp_le(cmp_a, cmp_b);
        le_s2 <= le_s1;
    end
    assign cmp_le = le_s2;

    typedef struct {
        logic [1:0] id;
        logic       le;
    } exp_t;

    exp_t sb_q[$];
    int   gnt_log[$];
    logic exp_le_of [NREQ];
    int   n_acc;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept monitor: records grants and pushes expected responses.
    always @(negedge clk) begin
        if (rst) begin
            if (req_ready != '0) check("grant_onehot", 64'($onehot(req_ready)), 64'(1));
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back('{id: 2'(i), le: exp_le_of[i]});
                    gnt_log.push_back(i);
                    n_acc++;
                end
            end
        end
    end

    // Response monitor: pops and compares whenever a response is consumed.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_id), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_le", 64'(rsp_le), 64'(e.le));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [32:0] a, input logic [32:0] b,
                           input logic le);
        req_a[i*OPW +: OPW] = a;
        req_b[i*OPW +: OPW] = b;
        exp_le_of[i]        = le;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        sb_q.delete();
        gnt_log.delete();
        n_acc = 0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rsp_valid || sb_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(busy || rsp_valid || sb_q.size() != 0), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst       = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        n_acc     = 0;
        for (int i = 0; i < NREQ; i++) exp_le_of[i] = 1'b0;

        // Reset state with all requesters asserting valid.
        repeat (2) step();
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cmp_a", 64'(cmp_a), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_le", 64'(rsp_le), 64'(0));
        req_valid = '0;
        rst       = 1'b1;

        // Single request latency: accept at E, rsp_valid after E+3.
        rsp_ready = 1'b1;
        set_req(0, ONE, TWO, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        check("lat_ready", 64'(req_ready), 64'(1));
        step();
        req_valid = '0;
        check("lat_cmp_a", 64'(cmp_a), 64'(ONE));
        check("lat_busy", 64'(busy), 64'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lat_early", 64'(rsp_valid), 64'(0));
        end
        @(negedge clk);
        check("lat_valid", 64'(rsp_valid), 64'(1));
        wait_idle("drain_single");

        set_req(0, TWO, ONE, 1'b0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        wait_idle("drain_swapped");

        set_req(3, NEG2, ONE, 1'b1);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        wait_idle("drain_req3");

        // Burst from ptr=0.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, ONE, TWO, 1'b1);
        set_req(1, TWO, ONE, 1'b0);
        set_req(2, NEG2, ONE, 1'b1);
        set_req(3, ONE, NEG2, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("burst_grant", 64'(req_ready), 64'(1 << k));
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("burst_cont", 64'(rsp_valid), 64'(1));
        end
        wait_idle("drain_burst");
        check("burst_order", 64'({gnt_log[0][1:0], gnt_log[1][1:0], gnt_log[2][1:0],
                                  gnt_log[3][1:0]}), 64'h1B);

        // Fairness between req0 and req2.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, ONE, TWO, 1'b1);
        set_req(2, TWO, ONE, 1'b0);
        req_valid = 4'b0101;
        repeat (8) step();
        req_valid = '0;
        check("fair_count", 64'(gnt_log.size()), 64'(8));
        bad = 0;
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) begin
            if (gnt_log[k] != ((k % 2 == 0) ? 0 : 2)) bad++;
        end
        check("fair_order", 64'(bad), 64'(0));
        wait_idle("drain_fair");

        // Back-pressure: credits allow exactly five accepts.
        do_reset();
        set_req(0, NEG2, TWO, 1'b1);
        req_valid = 4'b0001;
        repeat (10) step();
        check("bp_accepts", 64'(n_acc), 64'(5));
        @(negedge clk);
        check("bp_blocked", 64'(req_ready), 64'(0));
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        check("bp_busy", 64'(busy), 64'(1));
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_still_blocked", 64'(req_ready), 64'(0));
        step();
        @(negedge clk);
        check("bp_resume", 64'(req_ready), 64'(1));
        step();
        req_valid = '0;
        check("bp_total", 64'(n_acc), 64'(6));
        wait_idle("drain_bp");

        // Reset with three requests in flight.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, ONE, TWO, 1'b1);
        set_req(1, TWO, ONE, 1'b0);
        set_req(2, ONE, TWO, 1'b1);
        req_valid = 4'h7;
        repeat (3) step();
        req_valid = '0;
        check("mid_busy_before", 64'(busy), 64'(1));
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) step();
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
        end
        check("mid_no_stale", 64'(bad), 64'(0));

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
